sa_tile_engine: RTL
===================

# sa_tile_engine

Parametrised weight-stationary systolic matrix engine; successor of the fixed 64-column array wrapper. Computes OUT = X·W for X (X_R×S) and W (S×N) in signed fixed point, skewing X rows into the array, de-skewing column results into an output buffer, and signalling completion with a start/ready/done handshake. Generalised in data width, fraction bits, output columns and step rate. Adds an accumulate mode for K-tiling (K > S) and a synchronous abort. Sits between the attention controller and the Q/K/V projection buffers.

## Interface
- S, 64: array rows, the reduction length per pass.
- N, 64: array columns, the output width.
- X_R, 64: rows of X and of OUT.
- DW, 16: data width, signed two's complement.
- FRAC, 13: fraction bits.
- STEP_CYC, 1: clocks per array step (≥1; the legacy array used 5).
- I_CLK  in  1  clock.
- I_RST_N  in  1  asynchronous active-low reset.
- I_START  in  1  start request; accepted only when O_READY=1.
- I_ACC  in  1  sampled with accepted start; 1 = add results into the existing buffer.
- I_ABORT  in  1  synchronous abort.
- I_X  in  S·X_R·DW  X[r][j] at bits (j·X_R+r)·DW; must be held stable while busy.
- I_W  in  S·N·DW  W[j][c] at bits (j·N+c)·DW; must be held stable while busy.
- O_READY  out  1  idle, start may be issued.
- O_DONE  out  1  one-cycle pulse, O_OUT complete.
- O_OUT  out  X_R·N·DW  OUT[r][c] at bits (r·N+c)·DW; driven directly from the buffer.

## Operation
- FSM: IDLE → RUN on accepted start. RUN → DONE after T = X_R+S+N−1 steps. DONE → IDLE after one cycle. I_ABORT in RUN or DONE → IDLE, with no O_DONE.
- Step tick: a divider counter inside RUN ticks every STEP_CYC clocks. PE registers and buffer capture change only on ticks.
- PE(j,c), per tick: x_out ← x_in; psum_out ← psum_in + trunc(x_in·W[j][c]).
  - psum_in of row 0 is 0.
  - x_in of PE(j,0) at tick k (k from 0) is X[k−j][j] when 0 ≤ k−j < X_R, else 0.
- Capture at tick k: the bottom psum of column c, produced at tick k−1, is row r = k−1−(S−1)−c. When 0 ≤ r < X_R: buf[r][c] ← I_ACC ? buf+psum : psum.
- Arithmetic:
  - Product is 2·DW signed, arithmetically shifted right by FRAC (floor), then reduced to DW bits.
  - Every add (PE and accumulate) reduces to DW bits by the same rule; see Configuration.
- PE registers clear on accepted start and on abort. The buffer is never cleared except by reset.
- I_START while not ready: ignored. I_START together with I_ABORT in IDLE: start wins.
- Reset, asynchronous at any time: IDLE, counters 0, PEs 0, buffer 0.
  - Reset values: O_READY=1, O_DONE=0, O_OUT=0.

## Timing
- Start accepted in cycle 0. Tick k (k = 0..T−1) occurs at cycle (k+1)·STEP_CYC.
- O_DONE=1 at cycle T·STEP_CYC+1; O_OUT is final in that cycle.
- O_READY: low from cycle 1 through the O_DONE cycle; high again the cycle after O_DONE.
- Abort: O_READY is high the cycle after I_ABORT is sampled. Partially captured buffer rows remain.

## Configuration
- SA_SAT_EN defined: every product and sum saturates to [−2^(DW−1), 2^(DW−1)−1].
- SA_SAT_EN not defined: products and sums wrap by keeping the low DW bits.

## Structure
- Shared package sa_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the reduction function for saturate or wrap;
  - index helper constants for the flat-bus layouts.
- Sub-module sa_tile_pe: one PE (x register, psum register, multiply and reduce), instanced S×N in a generate grid.
- The top level holds the FSM, step divider, tick counter, X skew mux and de-skew capture.

## Test plan
- Identity multiply.
  - Stimulus: S=N=X_R=2, STEP_CYC=1, X = identity (0x2000 on the diagonal), W = [[0x0800,0x1000],[0x1800,0x2000]].
  - Response: O_OUT = W; O_DONE at cycle 6; O_READY high at cycle 7.
- Accumulate.
  - Stimulus: repeat the identity case with I_ACC=1.
  - Response: O_OUT = [[0x1000,0x2000],[0x3000,0x4000]].
- Overflow.
  - Stimulus: X[0] = [0x4000,0], W[0][0] = 0x4000.
  - Response: OUT[0][0] = 0x7FFF with SA_SAT_EN; 0x8000 without.
- STEP_CYC.
  - Stimulus: STEP_CYC=5 with the identity case.
  - Response: O_DONE at cycle 26; results identical.
- Abort.
  - Stimulus: assert I_ABORT at cycle 3.
  - Response: no O_DONE; O_READY=1 at cycle 4; a new start completes correctly.
- Reset mid-run.
  - Stimulus: drop I_RST_N at cycle 2.
  - Response: O_OUT=0, O_READY=1, O_DONE=0 immediately.
  - Start while busy is ignored, and O_DONE timing is unchanged.

Source files
------------

// File: rtl/sa_tile_engine_pkg.sv
// Shared types and helpers for the systolic tile engine.
// SA_SAT_EN selects saturating reduction; otherwise results wrap to DW bits.
package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_t;

    // Flat-bus layouts: X[r][j], W[j][c], OUT[r][c]
    function automatic int unsigned sa_x_lsb(input int unsigned r, input int unsigned j,
                                             input int unsigned x_r, input int unsigned dw);
        return (j * x_r + r) * dw;
    endfunction

    function automatic int unsigned sa_w_lsb(input int unsigned j, input int unsigned c,
                                             input int unsigned n, input int unsigned dw);
        return (j * n + c) * dw;
    endfunction

    function automatic int unsigned sa_o_lsb(input int unsigned r, input int unsigned c,
                                             input int unsigned n, input int unsigned dw);
        return (r * n + c) * dw;
    endfunction

    // Reduce a sign-extended value to dw bits; result stays sign-extended to 64.
    function automatic logic signed [63:0] sa_reduce(input logic signed [63:0] v,
                                                     input int unsigned dw);
`ifdef SA_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        logic signed [63:0] sh;
        sh = v <<< (64 - dw);
        return sh >>> (64 - dw);
`endif
    endfunction

endpackage

// File: rtl/sa_tile_engine_if.sv
// Start/ready/done handshake and flat operand/result buses of the tile engine.
interface sa_tile_engine_if #(
    parameter int unsigned S   = 64,
    parameter int unsigned N   = 64,
    parameter int unsigned X_R = 64,
    parameter int unsigned DW  = 16
);
    logic                   I_START;
    logic                   I_ACC;
    logic                   I_ABORT;
    logic [S*X_R*DW-1:0]    I_X;
    logic [S*N*DW-1:0]      I_W;
    logic                   O_READY;
    logic                   O_DONE;
    logic [X_R*N*DW-1:0]    O_OUT;

    modport master (
        output I_START, I_ACC, I_ABORT, I_X, I_W,
        input  O_READY, O_DONE, O_OUT
    );

    modport slave (
        input  I_START, I_ACC, I_ABORT, I_X, I_W,
        output O_READY, O_DONE, O_OUT
    );
endinterface

// File: rtl/sa_tile_engine_pe.sv
// One weight-stationary processing element: passes x right, adds x*W into psum.
module sa_tile_pe
    import sa_pkg::*;
#(
    parameter int unsigned DW   = 16,
    parameter int unsigned FRAC = 13
) (
    input  logic                 I_CLK,
    input  logic                 I_RST_N,
    input  logic                 i_clr,
    input  logic                 i_tick,
    input  logic signed [DW-1:0] i_x,
    input  logic signed [DW-1:0] i_w,
    input  logic signed [DW-1:0] i_psum,
    output logic signed [DW-1:0] o_x,
    output logic signed [DW-1:0] o_psum
);
    logic signed [2*DW-1:0] w_prod;
    logic signed [2*DW-1:0] w_prod_sh;
    logic signed [DW-1:0]   w_prod_red;
    logic signed [DW-1:0]   w_sum;
    logic signed [DW-1:0]   r_x;
    logic signed [DW-1:0]   r_psum;

    assign w_prod     = i_x * i_w;
    assign w_prod_sh  = w_prod >>> FRAC;
    assign w_prod_red = DW'(sa_reduce(64'(w_prod_sh), DW));
    assign w_sum      = DW'(sa_reduce(64'(i_psum) + 64'(w_prod_red), DW));

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_x    <= '0;
            r_psum <= '0;
        end else if (i_clr) begin
            r_x    <= '0;
            r_psum <= '0;
        end else if (i_tick) begin
            r_x    <= i_x;
            r_psum <= w_sum;
        end
    end

    assign o_x    = r_x;
    assign o_psum = r_psum;
endmodule

// File: rtl/sa_tile_engine.sv
// Systolic tile engine top: FSM, step divider, X skew, PE grid and de-skew capture buffer.
module sa_tile_engine
    import sa_pkg::*;
#(
    parameter int unsigned S        = 64,
    parameter int unsigned N        = 64,
    parameter int unsigned X_R      = 64,
    parameter int unsigned DW       = 16,
    parameter int unsigned FRAC     = 13,
    parameter int unsigned STEP_CYC = 1
) (
    input  logic            I_CLK,
    input  logic            I_RST_N,
    sa_tile_engine_if.slave bus
);
    localparam int unsigned T     = X_R + S + N - 1;
    localparam int unsigned KW    = $clog2(T + 1);
    localparam int unsigned DIV_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

    sa_state_t          r_state;
    sa_state_t          w_next;
    logic [DIV_W-1:0]   r_div;
    logic [KW-1:0]      r_k;
    logic               r_acc;
    logic               w_start;
    logic               w_tick;
    logic               w_clr;
    logic               w_ready;
    logic               w_done;

    logic signed [DW-1:0] w_xin  [S];
    logic signed [DW-1:0] w_x    [S][N];
    logic signed [DW-1:0] w_psum [S][N];
    logic signed [DW-1:0] r_buf  [X_R][N];

    assign w_start = (r_state == ST_IDLE) && bus.I_START;
    assign w_tick  = (r_state == ST_RUN) && !bus.I_ABORT && (r_div == DIV_W'(STEP_CYC - 1));
    assign w_clr   = w_start || bus.I_ABORT;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.I_START) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.I_ABORT)                          w_next = ST_IDLE;
                else if (w_tick && (r_k == KW'(T - 1)))   w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = !bus.I_ABORT;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign bus.O_READY = w_ready;
    assign bus.O_DONE  = w_done;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_div <= '0;
            r_k   <= '0;
            r_acc <= 1'b0;
        end else if (w_start) begin
            r_div <= '0;
            r_k   <= '0;
            r_acc <= bus.I_ACC;
        end else if ((r_state == ST_RUN) && !bus.I_ABORT) begin
            if (w_tick) begin
                r_div <= '0;
                r_k   <= r_k + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end else begin
            r_div <= '0;
            r_k   <= '0;
        end
    end

    // Row j sees X[k-j][j] at tick k, zero outside the valid window
    always_comb begin
        for (int unsigned j = 0; j < S; j++) w_xin[j] = '0;
        for (int unsigned j = 0; j < S; j++) begin
            for (int unsigned r = 0; r < X_R; r++) begin
                if (32'(r_k) == j + r) w_xin[j] = bus.I_X[sa_x_lsb(r, j, X_R, DW) +: DW];
            end
        end
    end

    for (genvar j = 0; j < S; j++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic signed [DW-1:0] w_pe_x;
            logic signed [DW-1:0] w_pe_psum;

            if (c == 0) begin : g_xl
                assign w_pe_x = w_xin[j];
            end else begin : g_xn
                assign w_pe_x = w_x[j][c-1];
            end

            if (j == 0) begin : g_pt
                assign w_pe_psum = '0;
            end else begin : g_pn
                assign w_pe_psum = w_psum[j-1][c];
            end

            sa_tile_pe #(
                .DW   (DW),
                .FRAC (FRAC)
            ) u_pe (
                .I_CLK   (I_CLK),
                .I_RST_N (I_RST_N),
                .i_clr   (w_clr),
                .i_tick  (w_tick),
                .i_x     (w_pe_x),
                .i_w     (bus.I_W[sa_w_lsb(j, c, N, DW) +: DW]),
                .i_psum  (w_pe_psum),
                .o_x     (w_x[j][c]),
                .o_psum  (w_psum[j][c])
            );
        end
    end

    // Bottom psum of column c at tick k belongs to row k-S-c
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int unsigned r = 0; r < X_R; r++)
                for (int unsigned c = 0; c < N; c++)
                    r_buf[r][c] <= '0;
        end else if (w_tick) begin
            for (int unsigned r = 0; r < X_R; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                    if (32'(r_k) == r + S + c) begin
                        r_buf[r][c] <= r_acc
                            ? DW'(sa_reduce(64'(r_buf[r][c]) + 64'(w_psum[S-1][c]), DW))
                            : w_psum[S-1][c];
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < X_R; r++) begin : g_or
        for (genvar c = 0; c < N; c++) begin : g_oc
            assign bus.O_OUT[sa_o_lsb(r, c, N, DW) +: DW] = r_buf[r][c];
        end
    end
endmodule
